// File: rtl/seq_match_logger.sv
// Timestamps "101" detector match pulses with a bit-time counter and queues them in a FIFO.
// Also tracks a saturating match count and a sticky overflow flag for drops on a full FIFO.
module seq_match_logger #(
    parameter int TS_W  = 8,
    parameter int CNT_W = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     det,
    input  logic                     clr,
    input  logic                     ts_ready,
    output logic                     ts_valid,
    output logic [TS_W-1:0]          ts_data,
    output logic [CNT_W-1:0]         match_cnt,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [TS_W-1:0] tcnt;
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [TS_W-1:0] mem [DEPTH];

    logic push;
    logic pop;
    logic full;
    logic accept;

    assign push     = en & det;
    assign full     = (level == LW'(DEPTH));
    assign ts_valid = (level != '0);
    assign pop      = ts_valid & ts_ready;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign accept   = push & (~full | pop);
    assign ts_data  = ts_valid ? mem[rptr] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt      <= '0;
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
            match_cnt <= '0;
            overflow  <= 1'b0;
        end else if (clr) begin
            tcnt      <= '0;
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
            match_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            if (en)
                tcnt <= tcnt + TS_W'(1);
            if (accept)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            case ({accept, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (push && full && !pop)
                overflow <= 1'b1;
            if (push && (match_cnt != {CNT_W{1'b1}}))
                match_cnt <= match_cnt + CNT_W'(1);
        end
    end

    // NOTE: storage has no reset; ts_data is gated by ts_valid, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (accept && !clr)
            mem[wptr] <= tcnt;
    end

endmodule

// File: tb/tb_seq_match_logger.sv
// Self-checking bench for seq_match_logger: directed scenarios plus random traffic
// compared against a queue-based model of the logger.
module tb_seq_match_logger;

    localparam int TS_W  = 8;
    localparam int CNT_W = 8;
    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   en;
    logic                   det;
    logic                   clr;
    logic                   ts_ready;
    logic                   ts_valid;
    logic [TS_W-1:0]        ts_data;
    logic [CNT_W-1:0]       match_cnt;
    logic [$clog2(DEPTH):0] level;
    logic                   overflow;

    seq_match_logger #(.TS_W(TS_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .det       (det),
        .clr       (clr),
        .ts_ready  (ts_ready),
        .ts_valid  (ts_valid),
        .ts_data   (ts_data),
        .match_cnt (match_cnt),
        .level     (level),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: bit-time, queued stamps, match count, sticky overflow.
    int m_t;
    int m_cnt;
    bit m_ov;
    int m_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_t   = 0;
        m_cnt = 0;
        m_ov  = 1'b0;
        m_q.delete();
    endtask

    task automatic check_model(input string tag);
        check({tag, "_valid"},    ts_valid,  (m_q.size() != 0));
        check({tag, "_level"},    level,     m_q.size());
        check({tag, "_match"},    match_cnt, m_cnt);
        check({tag, "_overflow"}, overflow,  m_ov);
        if (m_q.size() != 0)
            check({tag, "_data"}, ts_data, m_q[0]);
    endtask

    task automatic step(input bit e, input bit d, input bit c, input bit r, input string tag);
        bit do_pop;
        en       = e;
        det      = d;
        clr      = c;
        ts_ready = r;
        if (c) begin
            model_reset();
        end else begin
            do_pop = (m_q.size() != 0) && r;
            if (e && d) begin
                if (m_cnt < (1 << CNT_W) - 1)
                    m_cnt++;
                if (m_q.size() < DEPTH || do_pop)
                    m_q.push_back(m_t);
                else
                    m_ov = 1'b1;
            end
            if (do_pop)
                void'(m_q.pop_front());
            if (e)
                m_t = (m_t + 1) % (1 << TS_W);
        end
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < DEPTH + 1; k++)
            if (m_q.size() != 0)
                step(1'b1, 1'b0, 1'b0, 1'b1, tag);
    endtask

    initial begin
        rst      = 1'b0;
        en       = 1'b0;
        det      = 1'b0;
        clr      = 1'b0;
        ts_ready = 1'b0;
        model_reset();
        #12;
        check("reset_valid", ts_valid, 0);
        check("reset_level", level, 0);
        check("reset_match", match_cnt, 0);
        check("reset_overflow", overflow, 0);
        check("reset_data", ts_data, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Pulses at bit-times 2 and 5, then drain.
        for (int i = 0; i < 6; i++)
            step(1'b1, (i == 2 || i == 5), 1'b0, 1'b0, "basic");
        check("basic_level2", level, 2);
        check("basic_head2", ts_data, 2);
        step(1'b1, 1'b0, 1'b0, 1'b1, "basic_pop1");
        check("basic_head5", ts_data, 5);
        step(1'b1, 1'b0, 1'b0, 1'b1, "basic_pop2");
        check("basic_empty", ts_valid, 0);
        check("basic_match2", match_cnt, 2);

        // Overflow: six matches into four slots.
        step(1'b0, 1'b0, 1'b1, 1'b0, "ovf_clr");
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b1, 1'b0, 1'b0, "ovf_fill");
        check("ovf_level4", level, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_match6", match_cnt, 6);
        for (int k = 0; k < DEPTH; k++) begin
            check("ovf_drain_stamp", ts_data, k);
            step(1'b1, 1'b0, 1'b0, 1'b1, "ovf_drain");
        end
        check("ovf_drained", ts_valid, 0);
        check("ovf_sticky", overflow, 1);

        // Full FIFO with simultaneous push and pop.
        step(1'b0, 1'b0, 1'b1, 1'b0, "fullpp_clr");
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 1'b1, 1'b0, 1'b0, "fullpp_fill");
        step(1'b1, 1'b1, 1'b0, 1'b1, "fullpp_both");
        check("fullpp_level", level, 4);
        check("fullpp_noovf", overflow, 0);
        for (int k = 1; k <= DEPTH; k++) begin
            check("fullpp_order", ts_data, k);
            step(1'b1, 1'b0, 1'b0, 1'b1, "fullpp_drain");
        end

        // Enable gating and bit-time wrap.
        step(1'b0, 1'b0, 1'b1, 1'b0, "en_clr");
        step(1'b1, 1'b1, 1'b0, 1'b0, "en_first");
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 1'b0, 1'b0, "en_off");
        check("en_off_level", level, 1);
        check("en_off_match", match_cnt, 1);
        step(1'b1, 1'b1, 1'b0, 1'b0, "en_resume");
        step(1'b1, 1'b0, 1'b0, 1'b1, "en_pop0");
        check("en_resume_stamp", ts_data, 1);
        drain("en_drain");
        for (int i = 0; i < 300; i++)
            step(1'b1, (m_t == 0) || ($urandom_range(0, 15) == 0), 1'b0, 1'b1, "wrap");

        // Clear beats simultaneous match and pop.
        step(1'b0, 1'b0, 1'b1, 1'b0, "clr_pre");
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 1'b0, 1'b0, "clr_fill");
        step(1'b1, 1'b1, 1'b1, 1'b1, "clr_hit");
        check("clr_level", level, 0);
        check("clr_match", match_cnt, 0);
        check("clr_valid", ts_valid, 0);

        // Match-count saturation.
        for (int i = 0; i < 300; i++)
            step(1'b1, 1'b1, 1'b0, 1'($urandom_range(0, 1)), "sat");
        check("sat_match", match_cnt, (1 << CNT_W) - 1);

        // Random traffic.
        step(1'b0, 1'b0, 1'b1, 1'b0, "rnd_clr");
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), "rnd");

        // Asynchronous reset mid-cycle with three entries queued.
        step(1'b0, 1'b0, 1'b1, 1'b0, "arst_clr");
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 1'b0, 1'b0, "arst_fill");
        check("arst_pre_level", level, 3);
        en  = 1'b1;
        det = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", ts_valid, 0);
        check("arst_level", level, 0);
        check("arst_match", match_cnt, 0);
        check("arst_overflow", overflow, 0);
        check("arst_data", ts_data, 0);
        model_reset();
        @(posedge clk);
        #1;
        check("arst_hold_level", level, 0);
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b0, "arst_resume");
        check("arst_resume_stamp", ts_data, 0);
        drain("arst_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_match_logger.md
SEQ_MATCH_LOGGER -- requirements
Module: seq_match_logger

Interface
REQ-001 Parameters SHALL be: TS_W, default 8, timestamp width; CNT_W, default 8, match-count width; DEPTH, default 4, FIFO entries (power of 2, >=2).
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock; one detector bit-time per cycle.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 en  input  1  logging enable; bit-time counter advances and det is sampled only when 1.
REQ-006 det  input  1  one-cycle match pulse from the upstream "101" detector output.
REQ-007 clr  input  1  synchronous clear of FIFO, counters and overflow flag.
REQ-008 ts_ready  input  1  downstream accepts the head entry when high together with ts_valid.
REQ-009 ts_valid  output  1  FIFO non-empty; ts_data is valid.
REQ-010 ts_data  output  TS_W  bit-time stamp of the oldest unread match.
REQ-011 match_cnt  output  CNT_W  total accepted-or-dropped matches since reset/clr, saturating.
REQ-012 level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
REQ-013 overflow  output  1  sticky; set when a match is dropped because the FIFO is full.

Function
REQ-014 A free-running bit-time counter tcnt (TS_W bits) SHALL increment by 1 each cycle with en=1 and wrap from 2^TS_W-1 to 0; it holds when en=0.
REQ-015 A match event SHALL be det=1 and en=1 on a rising edge; det with en=0 is ignored entirely.
REQ-016 On a match event the value of tcnt in that same cycle (before its increment) SHALL be the pushed timestamp.
REQ-017 Push latency: match in cycle N -> entry visible (ts_valid=1, level updated) after edge N+1; no combinational bypass from det to ts_valid or ts_data.
REQ-018 Pop SHALL occur on an edge with ts_valid=1 and ts_ready=1; ts_ready with ts_valid=0 has no effect.
REQ-019 ts_data SHALL hold steady while ts_valid=1 and ts_ready=0.
REQ-020 FIFO SHALL be first-in first-out with read/write pointers wrapping modulo DEPTH.
REQ-021 Push while full and no pop in the same cycle: entry dropped, overflow set to 1, FIFO contents and level unchanged.
REQ-022 Push and pop in the same cycle (including when full): both performed, level unchanged, no overflow.
REQ-023 Pop when level=1 with no push: ts_valid=0 after the edge.
REQ-024 match_cnt SHALL increment on every match event, dropped or not, and saturate at 2^CNT_W-1.
REQ-025 overflow SHALL remain 1 until clr or reset; pops do not clear it.
REQ-026 clr=1 SHALL, at the edge, empty the FIFO (level=0, ts_valid=0), zero tcnt and match_cnt, and clear overflow; clr has priority over a simultaneous match or pop, which are discarded.
REQ-027 level SHALL equal pushes minus pops since the last reset/clr and SHALL never exceed DEPTH.

Reset
REQ-028 While rst=0: ts_valid=0, level=0, match_cnt=0, overflow=0, tcnt=0, pointers=0, ts_data=0.
REQ-029 Assertion of rst SHALL take effect immediately, without waiting for a clock edge, and SHALL discard any in-flight push or pop; operation resumes on the first rising edge after deassertion.

Verification
REQ-030 Reset, en=1, det pulses in cycles 2 and 5, ts_ready=0 -> level=2, ts_data=2; raise ts_ready -> pops return 2 then 5, ts_valid=0 afterwards, match_cnt=2.
REQ-031 DEPTH=4, ts_ready=0, 6 det pulses -> level=4, overflow=1, match_cnt=6, drained data equals first 4 stamps only.
REQ-032 FIFO full, ts_ready=1 and det=1 in the same cycle -> level stays 4, overflow stays 0, new stamp appears last in drain order.
REQ-033 en=0 for 3 cycles with det pulsing -> no push, tcnt and match_cnt hold; TS_W=8 run past 255 -> stamp wraps to 0.
REQ-034 clr asserted together with det and pop -> next cycle level=0, match_cnt=0, overflow=0, ts_valid=0.
REQ-035 rst driven low mid-cycle with level=3 -> outputs reach REQ-028 values before the next clock edge.
